// File: rtl/chao_sheng_bo.sv
// chao_sheng_bo: ultrasonic obstacle-avoidance controller.
// Fires periodic trigger pulses, measures the echo width in microseconds and
// steers the H-bridge: forward when the path is clear, otherwise a timed
// reverse followed by a timed turn.
//
// Internal handshake: meas_valid is a single-cycle strobe with no ready.
// meas_obst is valid only in the cycle meas_valid is high, and the motor FSM
// either consumes it in that cycle (STOP/FWD) or drops it (BACK/TURN).
module chao_sheng_bo #(
    parameter int CLK_PER_US     = 50,
    parameter int DIST_TH_CM     = 20,
    parameter int ECHO_MAX_US    = 38000,
    parameter int TRIG_PERIOD_US = 60000,
    parameter int TRIG_HIGH_US   = 10,
    parameter int BACK_US        = 300000,
    parameter int TURN_US        = 300000
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       echo,
    output logic       trig,
    output logic [3:0] motor,
    output logic [1:0] dbg_state
);

    localparam int PRE_W   = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
    localparam int TRIG_W  = $clog2(TRIG_PERIOD_US + 1);
    localparam int ECHO_W  = $clog2(ECHO_MAX_US + 1);
    localparam int MAN_MAX = (BACK_US > TURN_US) ? BACK_US : TURN_US;
    localparam int MAN_W   = $clog2(MAN_MAX + 1);

    localparam logic [PRE_W-1:0]  PRE_LAST   = PRE_W'(CLK_PER_US - 1);
    localparam logic [TRIG_W-1:0] TRIG_LAST  = TRIG_W'(TRIG_PERIOD_US - 1);
    localparam logic [TRIG_W-1:0] TRIG_HIGH  = TRIG_W'(TRIG_HIGH_US);
    localparam logic [ECHO_W-1:0] ECHO_MAX   = ECHO_W'(ECHO_MAX_US);
    localparam logic [MAN_W-1:0]  BACK_LAST  = MAN_W'(BACK_US - 1);
    localparam logic [MAN_W-1:0]  TURN_LAST  = MAN_W'(TURN_US - 1);
    // Threshold kept in microseconds (58 us of echo per cm) so no divider is needed.
    localparam logic [31:0]       TH_US      = 32'(DIST_TH_CM * 58);

    localparam logic [3:0] CODE_STOP = 4'b0000;
    localparam logic [3:0] CODE_FWD  = 4'b1010;
    localparam logic [3:0] CODE_BACK = 4'b0101;
    localparam logic [3:0] CODE_TURN = 4'b1001;

    typedef enum logic [1:0] {
        ST_STOP = 2'd0,
        ST_FWD  = 2'd1,
        ST_BACK = 2'd2,
        ST_TURN = 2'd3
    } state_t;

    // ---------------- trigger generator ----------------
    logic [PRE_W-1:0]  trig_pre;
    logic [TRIG_W-1:0] trig_us;

    // Free-running us counter; trig is registered from the pre-edge count so the
    // first pulse begins right after the reset-release edge and is glitch-free.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            trig_pre <= '0;
            trig_us  <= '0;
            trig     <= 1'b0;
        end else begin
            trig <= (trig_us < TRIG_HIGH);
            if (trig_pre == PRE_LAST) begin
                trig_pre <= '0;
                trig_us  <= (trig_us == TRIG_LAST) ? '0 : trig_us + 1'b1;
            end else begin
                trig_pre <= trig_pre + 1'b1;
            end
        end
    end

    // ---------------- echo synchroniser and edges ----------------
    logic echo_s1, echo_s2, echo_d;
    logic echo_rise, echo_fall;

    // Two-flop synchroniser plus one delay stage for edge detection.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            echo_s1 <= 1'b0;
            echo_s2 <= 1'b0;
            echo_d  <= 1'b0;
        end else begin
            echo_s1 <= echo;
            echo_s2 <= echo_s1;
            echo_d  <= echo_s2;
        end
    end

    assign echo_rise = echo_s2 & ~echo_d;
    assign echo_fall = ~echo_s2 & echo_d;

    // ---------------- echo width measurement ----------------
    // Cycles are counted while echo_d is high: that covers exactly the cycles
    // the synchronised echo was high, including the last one seen at the fall.
    logic [PRE_W-1:0]  echo_pre;
    logic [ECHO_W-1:0] echo_us;
    logic [ECHO_W-1:0] echo_us_next;
    logic              us_tick;
    logic              is_near;
    logic              sat_done;
    logic              meas_valid;
    logic              meas_obst;

    assign us_tick      = echo_d && (echo_pre == PRE_LAST) && (echo_us != ECHO_MAX);
    assign echo_us_next = echo_us + ECHO_W'(us_tick);
    assign is_near      = (32'(echo_us_next) < TH_US);

    // Width counter, saturation report and end-of-pulse report.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            echo_pre   <= '0;
            echo_us    <= '0;
            sat_done   <= 1'b0;
            meas_valid <= 1'b0;
            meas_obst  <= 1'b0;
        end else begin
            meas_valid <= 1'b0;
            if (echo_rise) begin
                echo_pre <= '0;
                echo_us  <= '0;
                sat_done <= 1'b0;
            end else if (echo_d) begin
                echo_pre <= (echo_pre == PRE_LAST) ? '0 : echo_pre + 1'b1;
                echo_us  <= echo_us_next;
                if (echo_fall) begin
                    // Zero-width pulses are glitches; a saturated pulse was already reported.
                    if (!sat_done && (echo_us_next != '0)) begin
                        meas_valid <= 1'b1;
                        meas_obst  <= is_near;
                    end
                end else if (!sat_done && (echo_us_next == ECHO_MAX)) begin
                    // Echo timed out: nothing in range, report clear once.
                    meas_valid <= 1'b1;
                    meas_obst  <= 1'b0;
                    sat_done   <= 1'b1;
                end
            end
        end
    end

    // ---------------- motor state machine ----------------
    state_t           state_q, state_d;
    logic [3:0]       motor_d;
    logic [PRE_W-1:0] man_pre;
    logic [MAN_W-1:0] man_us;
    logic             man_tick;

    assign man_tick  = (man_pre == PRE_LAST);
    assign dbg_state = state_q;

    // Next state and the motor code that goes with it.
    always_comb begin
        state_d = state_q;
        motor_d = CODE_STOP;
        case (state_q)
            ST_STOP, ST_FWD: if (meas_valid) state_d = meas_obst ? ST_BACK : ST_FWD;
            ST_BACK:         if (man_tick && (man_us == BACK_LAST)) state_d = ST_TURN;
            ST_TURN:         if (man_tick && (man_us == TURN_LAST)) state_d = ST_FWD;
            default:         state_d = ST_STOP;
        endcase
        case (state_d)
            ST_FWD:  motor_d = CODE_FWD;
            ST_BACK: motor_d = CODE_BACK;
            ST_TURN: motor_d = CODE_TURN;
            default: motor_d = CODE_STOP;
        endcase
    end

    // State, registered motor output, and manoeuvre timer cleared on every state entry.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_q <= ST_STOP;
            motor   <= CODE_STOP;
            man_pre <= '0;
            man_us  <= '0;
        end else begin
            state_q <= state_d;
            motor   <= motor_d;
            if ((state_d != state_q) || !((state_q == ST_BACK) || (state_q == ST_TURN))) begin
                man_pre <= '0;
                man_us  <= '0;
            end else if (man_tick) begin
                man_pre <= '0;
                man_us  <= man_us + 1'b1;
            end else begin
                man_pre <= man_pre + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_chao_sheng_bo.sv
// tb_chao_sheng_bo: directed bench for the obstacle-avoidance controller.
// Timing parameters are scaled down so the whole run stays short:
// 4 clocks per us, 100 us trigger period, 1600 us echo timeout, 600 us manoeuvres.
module tb_chao_sheng_bo;

    localparam int CPU       = 4;
    localparam int BACK_US   = 600;
    localparam int TURN_US   = 600;
    localparam int BACK_CYC  = BACK_US * CPU;
    localparam int TURN_CYC  = TURN_US * CPU;

    localparam logic [3:0] STOP = 4'b0000;
    localparam logic [3:0] FWD  = 4'b1010;
    localparam logic [3:0] BACK = 4'b0101;
    localparam logic [3:0] TURN = 4'b1001;

    logic       sys_clk;
    logic       sys_rst_n;
    logic       echo;
    logic       trig;
    logic [3:0] motor;
    logic [1:0] dbg_state;

    int n_checks;
    int n_err;

    chao_sheng_bo #(
        .CLK_PER_US    (CPU),
        .DIST_TH_CM    (20),
        .ECHO_MAX_US   (1600),
        .TRIG_PERIOD_US(100),
        .TRIG_HIGH_US  (10),
        .BACK_US       (BACK_US),
        .TURN_US       (TURN_US)
    ) dut (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .echo     (echo),
        .trig     (trig),
        .motor    (motor),
        .dbg_state(dbg_state)
    );

    // clock / watchdog
    initial sys_clk = 1'b0;
    always #10 sys_clk = ~sys_clk;

    initial begin
        #(150000 * 20);
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    // scoreboard helper
    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // drivers
    task automatic do_reset();
        @(negedge sys_clk);
        sys_rst_n = 1'b0;
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
    endtask

    // Echo high across exactly n rising clock edges; returns at the falling edge of the pin.
    task automatic pulse(input int n);
        @(negedge sys_clk);
        echo = 1'b1;
        repeat (n) @(negedge sys_clk);
        echo = 1'b0;
    endtask

    // Number of consecutive sampled cycles, starting now, on which motor holds code.
    task automatic run_len(input logic [3:0] code, output int n);
        n = 0;
        while ((motor == code) && (n < 6000)) begin
            n++;
            @(negedge sys_clk);
        end
    endtask

    typedef struct {
        bit         rst_first;
        int         hi_cyc;
        logic [3:0] exp_motor;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int hi, lo, nb, nt;
        n_checks  = 0;
        n_err     = 0;
        sys_rst_n = 1'b0;
        echo      = 1'b0;

        // pulse widths in clocks (4 per us); threshold 1160 us = 4640 clocks
        vecs[0] = '{1'b1, 6000, FWD};   // 1500 us from STOP -> clear
        vecs[1] = '{1'b0, 4640, FWD};   // exactly 1160 us from FWD -> stays
        vecs[2] = '{1'b0, 4639, BACK};  // 1159.75 us truncates to 1159 -> obstacle
        vecs[3] = '{1'b1, 2320, BACK};  // 580 us (10 cm) from STOP
        vecs[4] = '{1'b1, 4636, BACK};  // exactly 1159 us from STOP
        vecs[5] = '{1'b1, 4,    BACK};  // 1 us, smallest valid width
        vecs[6] = '{1'b1, 3,    STOP};  // rounds to 0 us -> glitch, ignored
        vecs[7] = '{1'b1, 4643, FWD};   // 1160.75 us from STOP -> clear

        // reset values and trigger waveform
        repeat (3) @(negedge sys_clk);
        check("reset_motor", motor, STOP);
        check("reset_trig", trig, 0);
        sys_rst_n = 1'b1;
        @(negedge sys_clk);
        check("trig_first_cycle", trig, 1);
        hi = 0;
        while (trig && hi < 1000) begin hi++; @(negedge sys_clk); end
        check("trig_high_cycles", hi, 40);
        lo = 0;
        while (!trig && lo < 1000) begin lo++; @(negedge sys_clk); end
        check("trig_low_cycles", lo, 360);
        hi = 0;
        while (trig && hi < 1000) begin hi++; @(negedge sys_clk); end
        check("trig_second_high", hi, 40);
        check("idle_motor", motor, STOP);

        // table-driven single-pulse decisions, checked 4 clocks after the pin falls
        for (int i = 0; i < 8; i++) begin
            if (vecs[i].rst_first) do_reset();
            pulse(vecs[i].hi_cyc);
            repeat (4) @(negedge sys_clk);
            check($sformatf("vec%0d_motor", i), motor, vecs[i].exp_motor);
        end

        // full manoeuvre: BACK then TURN then FWD with exact durations
        do_reset();
        pulse(2320);
        repeat (4) @(negedge sys_clk);
        check("man_back_entry", motor, BACK);
        run_len(BACK, nb);
        check("man_back_cycles", nb, BACK_CYC);
        check("man_turn_entry", motor, TURN);
        run_len(TURN, nt);
        check("man_turn_cycles", nt, TURN_CYC);
        check("man_final_fwd", motor, FWD);

        // echoes during BACK and TURN are ignored and do not stretch the manoeuvre
        do_reset();
        pulse(2320);
        repeat (4) @(negedge sys_clk);
        check("ign_back_entry", motor, BACK);
        fork
            run_len(BACK, nb);
            begin repeat (20) @(negedge sys_clk); pulse(2000); end
        join
        check("ign_back_cycles", nb, BACK_CYC);
        fork
            run_len(TURN, nt);
            begin repeat (20) @(negedge sys_clk); pulse(4); end
        join
        check("ign_turn_cycles", nt, TURN_CYC);
        check("ign_final_fwd", motor, FWD);

        // echo held past the 1600 us timeout: clear reported while still high
        do_reset();
        echo = 1'b1;
        repeat (6400) @(negedge sys_clk);
        check("sat_before_timeout", motor, STOP);
        repeat (8) @(negedge sys_clk);
        check("sat_after_timeout", motor, FWD);
        repeat (8000 - 6408) @(negedge sys_clk);
        echo = 1'b0;
        repeat (8) @(negedge sys_clk);
        check("sat_fall_ignored", motor, FWD);

        // sub-cycle glitch from STOP
        do_reset();
        @(negedge sys_clk);
        #2 echo = 1'b1;
        #10 echo = 1'b0;
        repeat (8) @(negedge sys_clk);
        check("glitch_no_change", motor, STOP);

        // reset asserted in the middle of TURN
        pulse(4);
        repeat (4) @(negedge sys_clk);
        check("rst_back_entry", motor, BACK);
        repeat (BACK_CYC + 20) @(negedge sys_clk);
        check("rst_in_turn", motor, TURN);
        sys_rst_n = 1'b0;
        @(negedge sys_clk);
        check("rst_turn_motor", motor, STOP);
        check("rst_turn_trig", trig, 0);
        sys_rst_n = 1'b1;
        repeat (4) @(negedge sys_clk);
        check("rst_turn_stays_stop", motor, STOP);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
